fmt_receiver: RTL

Receive end of the formatter output interface in MCDF. Answers `fmt_req_i` with a one-cycle `fmt_grant_o` when enough buffer space is free, then captures the contiguous `fmt_start_i`..`fmt_end_i` data burst. It checks framing against the advertised length and channel, and commits only complete, well-formed packets to an internal FIFO. The FIFO is drained by a downstream valid/ready word stream. Serves as the sink model and bridge behind the MCDF formatter.

---
 rtl/mcdf_pkg.sv | 34 +++
 rtl/rx_pkt_fifo.sv | 69 ++++++
 rtl/fmt_receiver.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mcdf_pkg.sv
// Purpose: shared MCDF types and constants for the formatter receive path.
// Latency: none (declarations only).
// Backpressure: n/a.
package mcdf_pkg;

  // Channel id reserved by the formatter; never a legal request.
  localparam logic [1:0] CHID_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RECV  = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    ERR_NO_START = 2'd0,
    ERR_SHORT    = 2'd1,
    ERR_LONG     = 2'd2,
    ERR_ILLEGAL  = 2'd3
  } err_code_e;

  // One FIFO entry: {last, chid, data}, 35 bits.
  typedef struct packed {
    logic        last;
    logic [1:0]  chid;
    logic [31:0] data;
  } rx_word_t;

  // Packet lengths the formatter may advertise.
  function automatic logic len_legal(input logic [5:0] len);
    return (len == 6'd4) || (len == 6'd8) || (len == 6'd16) || (len == 6'd32);
  endfunction

endpackage

// File: rtl/rx_pkt_fifo.sv
// Purpose: packet FIFO with speculative write, commit and rollback; show-ahead read.
// Latency: a committed word is visible on rd_dat the cycle after its commit.
// Backpressure: rd_vld/rd_rdy on the read side; the writer must respect free_cnt.
module rx_pkt_fifo
  import mcdf_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     wr_vld,
  input  rx_word_t                 wr_dat,
  input  logic                     cmt_vld,
  input  logic                     rbk_vld,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output rx_word_t                 rd_dat,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  rx_word_t    mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] cmt_ptr;
  logic [AW:0] rd_ptr;

  // Free space counts speculative writes, so a granted burst can never overflow.
  assign free_cnt = DEPTH_V - (wr_ptr - rd_ptr);
  assign rd_vld   = (cmt_ptr != rd_ptr);
  // Gate with valid so an empty FIFO presents all-zero outputs.
  assign rd_dat   = rd_vld ? mem[rd_ptr[AW-1:0]] : '0;

  // Storage write at the speculative pointer; no reset needed on the array.
  always_ff @(posedge clk_i) begin
    if (wr_vld) begin
      mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
  end

  // Write-side pointers: rollback discards everything past the last commit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
    end else begin
      if (rbk_vld) begin
        wr_ptr <= cmt_ptr;
      end else if (wr_vld) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (cmt_vld) begin
        cmt_ptr <= wr_vld ? (wr_ptr + PTR_ONE) : wr_ptr;
      end
    end
  end

  // Read pointer advances on every accepted word.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr <= '0;
    end else if (rd_vld && rd_rdy) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/fmt_receiver.sv
// Purpose: formatter sink; grants requests, checks framing, commits good packets to a FIFO.
// Latency: grant 1 cycle after request; first word readable 1 cycle after the end beat.
// Backpressure: rx_valid_o/rx_ready_i downstream; requests held off until space is free.
module fmt_receiver
  import mcdf_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             fmt_req_i,
  input  logic [1:0]       fmt_chid_i,
  input  logic [5:0]       fmt_length_i,
  input  logic             fmt_start_i,
  input  logic [31:0]      fmt_data_i,
  input  logic             fmt_end_i,
  output logic             fmt_grant_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [31:0]      rx_data_o,
  output logic [1:0]       rx_chid_o,
  output logic             rx_last_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] pkt_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  rx_state_e   state;
  logic [1:0]  chid_q;
  logic [5:0]  len_q;
  logic [5:0]  beat_q;
  logic        req_q;

  logic        req_legal;
  logic        space_ok;
  logic        last_beat;
  logic        beat_vld;
  logic        wr_vld;
  logic        cmt_vld;
  logic        rbk_vld;
  rx_word_t    wr_dat;
  rx_word_t    rd_dat;
  logic [AW:0] free_cnt;

  assign req_legal = fmt_req_i && len_legal(fmt_length_i) && (fmt_chid_i != CHID_RSVD);
  // Reads in the request cycle are deliberately not credited.
  assign space_ok  = (free_cnt >= (AW+1)'(fmt_length_i));
  assign last_beat = (beat_q == (len_q - 6'd1));
  // The first beat only counts when it carries start; later beats always count.
  assign beat_vld  = (state == RECV) && ((beat_q != 6'd0) || fmt_start_i);
  assign wr_dat    = '{last: fmt_end_i, chid: chid_q, data: fmt_data_i};

  // Per-beat FIFO control: commit on a correctly placed end, roll back on bad framing.
  always_comb begin
    wr_vld  = 1'b0;
    cmt_vld = 1'b0;
    rbk_vld = 1'b0;
    if (beat_vld) begin
      wr_vld = 1'b1;
      if (fmt_end_i) begin
        cmt_vld = last_beat;
        rbk_vld = !last_beat;
      end else if (last_beat) begin
        rbk_vld = 1'b1;
      end
    end
  end

  // Request/grant/receive sequencing with registered grant and error outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      chid_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      req_q       <= 1'b0;
      fmt_grant_o <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
      pkt_cnt_o   <= '0;
    end else begin
      fmt_grant_o <= 1'b0;
      err_o       <= 1'b0;
      req_q       <= fmt_req_i;
      case (state)
        IDLE: begin
          if (req_legal && space_ok) begin
            chid_q      <= fmt_chid_i;
            len_q       <= fmt_length_i;
            fmt_grant_o <= 1'b1;
            state       <= GRANT;
          end else if (fmt_req_i && !req_legal && !req_q) begin
            // Only the rising edge of an illegal request is reported.
            err_o      <= 1'b1;
            err_code_o <= ERR_ILLEGAL;
          end
        end
        GRANT: begin
          beat_q <= '0;
          state  <= RECV;
        end
        RECV: begin
          if (!beat_vld) begin
            err_o      <= 1'b1;
            err_code_o <= ERR_NO_START;
            state      <= IDLE;
          end else if (cmt_vld) begin
            pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
            state     <= IDLE;
          end else if (rbk_vld) begin
            err_o      <= 1'b1;
            err_code_o <= fmt_end_i ? ERR_SHORT : ERR_LONG;
            state      <= IDLE;
          end else begin
            beat_q <= beat_q + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rx_pkt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .wr_vld   (wr_vld),
    .wr_dat   (wr_dat),
    .cmt_vld  (cmt_vld),
    .rbk_vld  (rbk_vld),
    .rd_vld   (rx_valid_o),
    .rd_rdy   (rx_ready_i),
    .rd_dat   (rd_dat),
    .free_cnt (free_cnt)
  );

  assign rx_data_o = rd_dat.data;
  assign rx_chid_o = rd_dat.chid;
  assign rx_last_o = rd_dat.last;

endmodule
